dccm_access_ctrl: RTL
=====================

# dccm_access_ctrl

Load/store sequencer that sits directly upstream of the memory wrapper's DCCM port. It accepts one byte/half/word access at a time from the LSU, drives the wrapper's dual-bank read/write strobes, addresses and 39-bit codewords, and consumes the returned lo/hi codewords. It performs SECDED check and correction, misaligned accesses that span two words, and read-modify-write for sub-word and misaligned stores.

## Interface
Parameters:
- DCCM_BITS, 16, byte-address width.
- DCCM_FDATA_WIDTH, 39, codeword width: {ecc[6:0], data[31:0]}.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- io_req_valid  in  1  request present; must hold with stable fields until accepted.
- io_req_ready  out  1  high only in IDLE.
- io_req_write  in  1  1 = store, 0 = load.
- io_req_addr  in  16  byte address.
- io_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- io_req_wdata  in  32  store data, right-justified.
- io_ecc_disable  in  1  suppress correction and error flags.
- io_resp_valid  out  1  one-cycle completion pulse.
- io_resp_data  out  32  load data, zero-extended; 0 for stores.
- io_resp_sb_err  out  1  single-bit error corrected.
- io_resp_db_err  out  1  uncorrectable error.
- io_dccm_rden, io_dccm_wren  out  1  memory strobes.
- io_dccm_rd_addr_lo/hi, io_dccm_wr_addr_lo/hi  out  16  word-aligned byte addresses.
- io_dccm_wr_data_lo/hi  out  39  codewords to write.
- io_dccm_rd_data_lo/hi  in  39  codewords, valid one cycle after rden.

## Operation
- Address terms:
  - W = addr[15:2]; off = addr[1:0]; nbytes = 1/2/4.
  - Access spans two words when off + nbytes > 4. The hi word is W+1 mod 2^14, so 0xFFFF wraps to word 0.
  - lo address = {W,2'b00}. hi address = {W+1,2'b00} if spanning, else equal to lo.
- ECC: the core's standard Hamming(39,32) SECDED, with bit 38 as overall parity.
  - Decode reports one of three outcomes per word: clean, single-bit (corrected), or double-bit (raw data kept).
  - Only words covered by the access contribute to the flags: the hi word counts only when the access spans.
  - When io_ecc_disable = 1: data is used raw and both flags are 0. ECC is still generated on writes.
- FSM states and transitions:
  - IDLE: ready = 1.
    - Accepting a read, sub-word store, or misaligned store captures the request and moves to RD.
    - Accepting an aligned word store (size = 2, off = 0) moves straight to WR with encoded wdata.
  - RD: rden = 1 with lo/hi addresses. Next state is CHK.
  - CHK: the memory codewords are valid in this cycle and are decoded.
    - Load: form {hi,lo} 64-bit >> 8·off, mask to nbytes, register as resp data with flags; resp_valid next cycle; go to IDLE.
    - Store, no double-bit error: merge wdata bytes into the corrected words, re-encode both, register them; go to WR.
    - Store with double-bit error: the write is aborted; resp_valid next cycle with db_err = 1; go to IDLE.
  - WR: wren = 1, wr addresses = captured lo/hi. For a non-spanning access, wr_data_hi equals wr_data_lo. Go to IDLE with resp_valid next cycle, carrying the sb flag from CHK.
- Strobes and addresses are driven from registered state. Addresses and write data hold their last values when strobes are low.

## Timing
- Reset (asynchronous): state = IDLE, all outputs 0 except io_req_ready = 1. A wren in flight drops immediately, and no partial write is issued.
- Load: accept at cycle 0, rden at 1, data at 2 (CHK), resp_valid at 3. A new request can be accepted at cycle 3.
- RMW store: accept at 0, rden at 1, CHK at 2, wren at 3, resp_valid at 4.
- Aligned word store: accept at 0, wren at 1, resp_valid at 2.
- resp_valid lasts exactly one cycle. resp_data and the flags are valid only while resp_valid is high.
- io_req_valid while not in IDLE is ignored, with no backpressure other than ready = 0.
- rden and wren are never high in the same cycle.

## Test plan
- Word 0x0000_0100 preloaded with 0xDEADBEEF (valid ECC); load word at 0x0100 → resp_valid at cycle 3, data 0xDEADBEEF, flags 0.
- Byte store 0xA5 to 0x0102 over 0x11223344 → rden at cycle 1, wren at cycle 3 with data 0x11A53344 and correct ECC, resp_valid at cycle 4.
- Half load at 0x0107, with word 0x0104 = 0xAABBCCDD and word 0x0108 = 0x11223344 → lo address 0x0104, hi address 0x0108, data 0x000044AA. Repeat at 0xFFFF → hi address 0x0000.
- Flip bit 5 of the lo codeword, then load → data corrected, sb_err = 1. Flip two bits on a half store → no wren, db_err = 1. Same single flip with io_ecc_disable = 1 → raw data returned, flags 0.
- Aligned word store 0x12345678 at 0x0200 → wren at cycle 1, no rden, resp_valid at cycle 2.
- Assert reset during CHK of an RMW store → wren never asserts, all outputs 0, ready = 1. After release, the next load completes normally.

Source files
------------

// File: rtl/dccm_access_ctrl.sv
// DCCM load/store sequencer: SECDED check/correct, two-word misaligned accesses,
// and read-modify-write for sub-word or misaligned stores.
module dccm_access_ctrl #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_req_valid,
  output logic                        io_req_ready,
  input  logic                        io_req_write,
  input  logic [DCCM_BITS-1:0]        io_req_addr,
  input  logic [1:0]                  io_req_size,
  input  logic [31:0]                 io_req_wdata,
  input  logic                        io_ecc_disable,
  output logic                        io_resp_valid,
  output logic [31:0]                 io_resp_data,
  output logic                        io_resp_sb_err,
  output logic                        io_resp_db_err,
  output logic                        io_dccm_rden,
  output logic                        io_dccm_wren,
  output logic [DCCM_BITS-1:0]        io_dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        io_dccm_rd_addr_hi,
  output logic [DCCM_BITS-1:0]        io_dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        io_dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] io_dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] io_dccm_wr_data_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] io_dccm_rd_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] io_dccm_rd_data_hi
);
  localparam int WW = DCCM_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_WR} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic        sb;
    logic        db;
  } dec_t;

  // Hamming check bits: data occupies positions 1..38 that are not powers of two.
  function automatic logic [5:0] ham_bits(input logic [31:0] d);
    logic [5:0] p;
    logic [5:0] k;
    p = '0;
    k = '0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int b = 0; b < 6; b++) if (pos[b]) p[b] = p[b] ^ d[k[4:0]];
        k = k + 6'd1;
      end
    end
    return p;
  endfunction

  function automatic logic [38:0] ecc_enc(input logic [31:0] d);
    logic [5:0] p;
    p = ham_bits(d);
    return {^{p, d}, p, d};
  endfunction

  function automatic dec_t ecc_dec(input logic [38:0] cw);
    logic [5:0] syn;
    logic       par;
    logic [5:0] k;
    dec_t       r;
    syn    = ham_bits(cw[31:0]) ^ cw[37:32];
    par    = ^cw;
    r.data = cw[31:0];
    r.sb   = par & (syn <= 6'd38);
    r.db   = (~par & (syn != 6'd0)) | (par & (syn > 6'd38));
    k      = '0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (par && syn == pos[5:0]) r.data[k[4:0]] = ~cw[k[4:0]];
        k = k + 6'd1;
      end
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic                  write_q, write_d, span_q, span_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [DCCM_BITS-1:0]  rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic [DCCM_BITS-1:0]  wr_lo_q, wr_lo_d, wr_hi_q, wr_hi_d;
  logic [38:0]           wd_lo_q, wd_lo_d, wd_hi_q, wd_hi_d;
  logic                  resp_valid_q, resp_valid_d, sb_q, sb_d, db_q, db_d;
  logic                  sb_pend_q, sb_pend_d;
  logic [31:0]           resp_data_q, resp_data_d;

  // Request decode
  logic [2:0]            req_nbytes;
  logic                  req_span;
  logic [WW-1:0]         req_w;
  logic [DCCM_BITS-1:0]  req_lo, req_hi;

  always_comb begin
    req_nbytes = (io_req_size == 2'd0) ? 3'd1 : (io_req_size == 2'd1) ? 3'd2 : 3'd4;
    req_span   = ({2'b00, io_req_addr[1:0]} + {1'b0, req_nbytes}) > 4'd4;
    req_w      = io_req_addr[DCCM_BITS-1:2];
    req_lo     = {req_w, 2'b00};
    req_hi     = req_span ? {req_w + WW'(1), 2'b00} : req_lo;
  end

  // CHK datapath: decode, extract load data, merge store data
  dec_t        dec_lo, dec_hi;
  logic [31:0] lo_data, hi_data, ld_mask, load_data;
  logic [63:0] dword, ld_shift, bm, merged;
  logic [7:0]  be8;
  logic [5:0]  shamt;
  logic        chk_sb, chk_db;

  always_comb begin
    dec_lo    = ecc_dec(io_dccm_rd_data_lo);
    dec_hi    = ecc_dec(io_dccm_rd_data_hi);
    lo_data   = io_ecc_disable ? io_dccm_rd_data_lo[31:0] : dec_lo.data;
    hi_data   = io_ecc_disable ? io_dccm_rd_data_hi[31:0] : dec_hi.data;
    chk_sb    = ~io_ecc_disable & (dec_lo.sb | (span_q & dec_hi.sb));
    chk_db    = ~io_ecc_disable & (dec_lo.db | (span_q & dec_hi.db));
    dword     = {hi_data, lo_data};
    shamt     = {1'b0, off_q, 3'b000};
    ld_shift  = dword >> shamt;
    ld_mask   = (nbytes_q == 3'd1) ? 32'h0000_00FF :
                (nbytes_q == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    load_data = ld_shift[31:0] & ld_mask;
    be8       = ((nbytes_q == 3'd1) ? 8'h01 : (nbytes_q == 3'd2) ? 8'h03 : 8'h0F) << off_q;
    for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{be8[i]}};
    merged    = (dword & ~bm) | (({32'b0, wdata_q} << shamt) & bm);
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    span_d       = span_q;
    off_d        = off_q;
    nbytes_d     = nbytes_q;
    wdata_d      = wdata_q;
    rd_lo_d      = rd_lo_q;
    rd_hi_d      = rd_hi_q;
    wr_lo_d      = wr_lo_q;
    wr_hi_d      = wr_hi_q;
    wd_lo_d      = wd_lo_q;
    wd_hi_d      = wd_hi_q;
    sb_pend_d    = sb_pend_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    sb_d         = sb_q;
    db_d         = db_q;
    unique case (state_q)
      S_IDLE: if (io_req_valid) begin
        write_d  = io_req_write;
        span_d   = req_span;
        off_d    = io_req_addr[1:0];
        nbytes_d = req_nbytes;
        wdata_d  = io_req_wdata;
        if (io_req_write && req_nbytes == 3'd4 && io_req_addr[1:0] == 2'd0) begin
          wr_lo_d   = req_lo;
          wr_hi_d   = req_lo;
          wd_lo_d   = ecc_enc(io_req_wdata);
          wd_hi_d   = ecc_enc(io_req_wdata);
          sb_pend_d = 1'b0;
          state_d   = S_WR;
        end else begin
          rd_lo_d = req_lo;
          rd_hi_d = req_hi;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        if (!write_q || chk_db) begin
          // Loads respond here; stores hitting an uncorrectable word abort the write.
          resp_valid_d = 1'b1;
          resp_data_d  = write_q ? 32'h0 : load_data;
          sb_d         = chk_sb;
          db_d         = chk_db;
          state_d      = S_IDLE;
        end else begin
          wr_lo_d   = rd_lo_q;
          wr_hi_d   = rd_hi_q;
          wd_lo_d   = ecc_enc(merged[31:0]);
          wd_hi_d   = span_q ? ecc_enc(merged[63:32]) : ecc_enc(merged[31:0]);
          sb_pend_d = chk_sb;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = 32'h0;
        sb_d         = sb_pend_q;
        db_d         = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      span_q       <= 1'b0;
      off_q        <= '0;
      nbytes_q     <= '0;
      wdata_q      <= '0;
      rd_lo_q      <= '0;
      rd_hi_q      <= '0;
      wr_lo_q      <= '0;
      wr_hi_q      <= '0;
      wd_lo_q      <= '0;
      wd_hi_q      <= '0;
      sb_pend_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      sb_q         <= 1'b0;
      db_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      span_q       <= span_d;
      off_q        <= off_d;
      nbytes_q     <= nbytes_d;
      wdata_q      <= wdata_d;
      rd_lo_q      <= rd_lo_d;
      rd_hi_q      <= rd_hi_d;
      wr_lo_q      <= wr_lo_d;
      wr_hi_q      <= wr_hi_d;
      wd_lo_q      <= wd_lo_d;
      wd_hi_q      <= wd_hi_d;
      sb_pend_q    <= sb_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      sb_q         <= sb_d;
      db_q         <= db_d;
    end
  end

  assign io_req_ready       = (state_q == S_IDLE);
  assign io_dccm_rden       = (state_q == S_RD);
  assign io_dccm_wren       = (state_q == S_WR);
  assign io_dccm_rd_addr_lo = rd_lo_q;
  assign io_dccm_rd_addr_hi = rd_hi_q;
  assign io_dccm_wr_addr_lo = wr_lo_q;
  assign io_dccm_wr_addr_hi = wr_hi_q;
  assign io_dccm_wr_data_lo = wd_lo_q;
  assign io_dccm_wr_data_hi = wd_hi_q;
  assign io_resp_valid      = resp_valid_q;
  assign io_resp_data       = resp_data_q;
  assign io_resp_sb_err     = sb_q;
  assign io_resp_db_err     = db_q;

endmodule
